// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive framing controller.
//   frame_state_e   : controller FSM states
//   SyncByteDefault : default frame start marker
//   chk_add         : one step of the 8-bit wrapping checksum
package uart_frame_pkg;

   typedef enum logic [2:0] {
      StHunt,
      StLen,
      StPayload,
      StCheck,
      StHold
   } frame_state_e;

   localparam logic [7:0] SyncByteDefault = 8'hA5;

   // Checksum is a plain modulo-256 sum; the carry is discarded on purpose.
   function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data);
      return acc + data;
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the framing controller.
//   clk   : system clock
//   we    : write enable, one byte per asserted cycle
//   waddr : write index
//   wdata : write byte
//   raddr : read index
//   rdata : mem[raddr], combinational
// Contents are not reset; only entries written by the current frame are meaningful.
module uart_frame_buf #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [7:0]                 wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [7:0]                 rdata
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Framing controller behind the UART receiver.
// Frames on the wire: SYNC, LEN, LEN payload bytes, CHK where CHK = LEN + sum(payload) mod 256.
//   clk, rst     : system clock, asynchronous active-high reset
//   rx_byte      : received byte, qualified by rx_valid
//   rx_valid     : single-cycle byte strobe
//   frame_valid  : a checked frame is held (level)
//   frame_len    : payload length of the held frame
//   frame_ack    : consumer releases the held frame
//   rd_addr      : payload read index
//   rd_data      : payload byte at rd_addr (combinational)
//   err_len      : pulse, LEN byte out of range
//   err_chk      : pulse, checksum mismatch
//   err_timeout  : pulse, inter-byte gap expired mid-frame
//   err_overrun  : pulse, byte dropped while a frame was held
module uart_rx_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault,
   parameter int unsigned TIMEOUT_CLKS = 8680
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 rx_byte,
   input  logic                       rx_valid,
   output logic                       frame_valid,
   output logic [$clog2(MAX_LEN):0]   frame_len,
   input  logic                       frame_ack,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
   output logic [7:0]                 rd_data,
   output logic                       err_len,
   output logic                       err_chk,
   output logic                       err_timeout,
   output logic                       err_overrun
);

   localparam int unsigned IdxW = $clog2(MAX_LEN);
   localparam int unsigned LenW = IdxW + 1;
   localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS);

   frame_state_e    state_q;
   logic [LenW-1:0] len_q;
   logic [IdxW-1:0] idx_q;
   logic [7:0]      acc_q;
   logic [TmoW-1:0] tmo_q;

   logic len_ok;
   logic last_byte;
   logic tmo_hit;
   logic buf_we;

   // Nine-bit compare so MAX_LEN == 256 is representable.
   assign len_ok    = (rx_byte != 8'd0) && ({1'b0, rx_byte} <= 9'(MAX_LEN));
   assign last_byte = ({1'b0, idx_q} == (len_q - LenW'(1)));
   assign tmo_hit   = (tmo_q == TmoW'(TIMEOUT_CLKS - 1));
   assign buf_we    = (state_q == StPayload) && rx_valid;

   uart_frame_buf #(
      .DEPTH (MAX_LEN)
   ) u_frame_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx_q),
      .wdata (rx_byte),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHunt;
         len_q       <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         tmo_q       <= '0;
         frame_valid <= 1'b0;
         frame_len   <= '0;
         err_len     <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_len     <= 1'b0;
         err_chk     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;

         unique case (state_q)
            StHunt: begin
               if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                  state_q <= StLen;
                  tmo_q   <= '0;
               end
            end

            StLen, StPayload, StCheck: begin
               if (!rx_valid) begin
                  // A byte in the expiry cycle takes priority, so only check here.
                  if (tmo_hit) begin
                     err_timeout <= 1'b1;
                     state_q     <= StHunt;
                  end else begin
                     tmo_q <= tmo_q + TmoW'(1);
                  end
               end else begin
                  tmo_q <= '0;
                  unique case (state_q)
                     StLen: begin
                        if (len_ok) begin
                           len_q   <= LenW'(rx_byte);
                           acc_q   <= rx_byte;
                           idx_q   <= '0;
                           state_q <= StPayload;
                        end else begin
                           err_len <= 1'b1;
                           state_q <= StHunt;
                        end
                     end
                     StPayload: begin
                        acc_q <= chk_add(acc_q, rx_byte);
                        idx_q <= idx_q + IdxW'(1);
                        if (last_byte) begin
                           state_q <= StCheck;
                        end
                     end
                     default: begin
                        if (rx_byte == acc_q) begin
                           frame_valid <= 1'b1;
                           frame_len   <= len_q;
                           state_q     <= StHold;
                        end else begin
                           err_chk <= 1'b1;
                           state_q <= StHunt;
                        end
                     end
                  endcase
               end
            end

            StHold: begin
               if (frame_ack) begin
                  frame_valid <= 1'b0;
                  frame_len   <= '0;
                  // Release and hunt in the same cycle so a SYNC riding on the ack is not lost.
                  if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                     state_q <= StLen;
                     tmo_q   <= '0;
                  end else begin
                     state_q <= StHunt;
                  end
               end else if (rx_valid) begin
                  err_overrun <= 1'b1;
               end
            end

            default: begin
               state_q <= StHunt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

   localparam int unsigned MAX_LEN      = 16;
   localparam int unsigned TIMEOUT_CLKS = 8680;

   logic       clk;
   logic       rst;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_valid;
   logic [4:0] frame_len;
   logic       frame_ack;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       err_len;
   logic       err_chk;
   logic       err_timeout;
   logic       err_overrun;

   int checks;
   int errors;

   uart_rx_frame_ctrl #(
      .MAX_LEN      (MAX_LEN),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .frame_valid (frame_valid),
      .frame_len   (frame_len),
      .frame_ack   (frame_ack),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .err_len     (err_len),
      .err_chk     (err_chk),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe one byte; returns at the falling edge after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] outs;
      repeat (2) @(negedge clk);
      outs = {frame_valid, err_len, err_chk, err_timeout, err_overrun};
      checks++;
      if (outs !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", outs); end
      checks++;
      if (frame_len !== 5'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", frame_len); end
      rst = 1'b0;
      @(negedge clk);
      outs = {frame_valid, err_len, err_chk, err_timeout, err_overrun};
      checks++;
      if (outs !== 5'b0) begin errors++; $display("FAIL post_reset_flags: got %b expected 00000", outs); end
   endtask

   task automatic test_good_frame();
      logic [7:0] exp_data [3];
      exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
      send_byte(8'hA5); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid: got %b expected 0", frame_valid); end
      send_byte(8'h69);
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", frame_valid); end
      checks++;
      if (frame_len !== 5'd3) begin errors++; $display("FAIL good_len: got %0d expected 3", frame_len); end
      for (int i = 0; i < 3; i++) begin
         rd_addr = 4'(i);
         #1;
         checks++;
         if (rd_data !== exp_data[i]) begin
            errors++; $display("FAIL good_data[%0d]: got %h expected %h", i, rd_data, exp_data[i]);
         end
      end
      pulse_ack();
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_release: got %b expected 0", frame_valid); end
   endtask

   task automatic test_bad_checksum();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
      checks++;
      if (err_chk !== 1'b1) begin errors++; $display("FAIL chk_pulse: got %b expected 1", err_chk); end
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL chk_no_valid: got %b expected 0", frame_valid); end
      @(negedge clk);
      checks++;
      if (err_chk !== 1'b0) begin errors++; $display("FAIL chk_pulse_width: got %b expected 0", err_chk); end
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
      checks++;
      if ({frame_valid, frame_len} !== {1'b1, 5'd1}) begin
         errors++; $display("FAIL chk_recover: got valid %b len %0d expected valid 1 len 1", frame_valid, frame_len);
      end
      rd_addr = 4'd0;
      #1;
      checks++;
      if (rd_data !== 8'h7F) begin errors++; $display("FAIL chk_recover_data: got %h expected 7f", rd_data); end
      pulse_ack();
   endtask

   task automatic test_length();
      send_byte(8'hA5); send_byte(8'h00);
      checks++;
      if (err_len !== 1'b1) begin errors++; $display("FAIL len_zero: got %b expected 1", err_len); end
      @(negedge clk);
      checks++;
      if (err_len !== 1'b0) begin errors++; $display("FAIL len_pulse_width: got %b expected 0", err_len); end
      send_byte(8'hA5); send_byte(8'h11);
      checks++;
      if (err_len !== 1'b1) begin errors++; $display("FAIL len_over: got %b expected 1", err_len); end
      send_byte(8'hA5); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
      // 16 + (0x10 + ... + 0x1F) = 392 = 0x188
      send_byte(8'h88);
      checks++;
      if ({frame_valid, frame_len} !== {1'b1, 5'd16}) begin
         errors++; $display("FAIL len_max: got valid %b len %0d expected valid 1 len 16", frame_valid, frame_len);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         checks++;
         if (rd_data !== 8'h10 + 8'(i)) begin
            errors++; $display("FAIL len_max_data[%0d]: got %h expected %h", i, rd_data, 8'h10 + 8'(i));
         end
      end
      pulse_ack();
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL len_max_release: got %b expected 0", frame_valid); end
   endtask

   task automatic test_timeout();
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
      repeat (TIMEOUT_CLKS - 1) @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", err_timeout); end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", err_timeout); end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b expected 0", err_timeout); end

      // Next byte lands exactly in the expiry cycle and must win.
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
      repeat (TIMEOUT_CLKS - 2) @(negedge clk);
      send_byte(8'hBB);
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_byte_wins: got %b expected 0", err_timeout); end
      // 4 + AA + BB + CC + DD = 786 = 0x312
      send_byte(8'hCC); send_byte(8'hDD); send_byte(8'h12);
      checks++;
      if ({frame_valid, frame_len} !== {1'b1, 5'd4}) begin
         errors++; $display("FAIL tmo_frame: got valid %b len %0d expected valid 1 len 4", frame_valid, frame_len);
      end
      rd_addr = 4'd1;
      #1;
      checks++;
      if (rd_data !== 8'hBB) begin errors++; $display("FAIL tmo_frame_data: got %h expected bb", rd_data); end
      pulse_ack();
   endtask

   task automatic test_overrun();
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h7A);
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_setup: got %b expected 1", frame_valid); end
      send_byte(8'h55);
      checks++;
      if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", err_overrun); end
      checks++;
      if ({frame_valid, frame_len} !== {1'b1, 5'd2}) begin
         errors++; $display("FAIL ovr_held: got valid %b len %0d expected valid 1 len 2", frame_valid, frame_len);
      end
      rd_addr = 4'd0;
      #1;
      checks++;
      if (rd_data !== 8'hAB) begin errors++; $display("FAIL ovr_data0: got %h expected ab", rd_data); end
      rd_addr = 4'd1;
      #1;
      checks++;
      if (rd_data !== 8'hCD) begin errors++; $display("FAIL ovr_data1: got %h expected cd", rd_data); end
      @(negedge clk);
      checks++;
      if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_width: got %b expected 0", err_overrun); end

      // SYNC together with the ack: release, no overrun, parse continues at LEN.
      @(negedge clk);
      rx_byte   = 8'hA5;
      rx_valid  = 1'b1;
      frame_ack = 1'b1;
      @(negedge clk);
      rx_valid  = 1'b0;
      frame_ack = 1'b0;
      checks++;
      if ({frame_valid, err_overrun} !== 2'b00) begin
         errors++; $display("FAIL ack_sync: got valid,overrun %b expected 00", {frame_valid, err_overrun});
      end
      send_byte(8'h01); send_byte(8'h3C); send_byte(8'h3D);
      checks++;
      if ({frame_valid, frame_len} !== {1'b1, 5'd1}) begin
         errors++; $display("FAIL ack_sync_frame: got valid %b len %0d expected valid 1 len 1", frame_valid, frame_len);
      end
      rd_addr = 4'd0;
      #1;
      checks++;
      if (rd_data !== 8'h3C) begin errors++; $display("FAIL ack_sync_data: got %h expected 3c", rd_data); end
      pulse_ack();
   endtask

   task automatic test_reset_mid();
      logic [4:0] outs;
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      outs = {frame_valid, err_len, err_chk, err_timeout, err_overrun};
      checks++;
      if (outs !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00000", outs); end
      @(negedge clk);
      rst = 1'b0;
      // Leftover bytes of the aborted frame are ignored in HUNT.
      send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'h0F);
      outs = {frame_valid, err_len, err_chk, err_timeout, err_overrun};
      checks++;
      if (outs !== 5'b0) begin errors++; $display("FAIL rst_stray: got %b expected 00000", outs); end
      // SYNC value inside the payload is ordinary data: 2 + A5 + 10 = 0xB7
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h10); send_byte(8'hB7);
      checks++;
      if ({frame_valid, frame_len} !== {1'b1, 5'd2}) begin
         errors++; $display("FAIL rst_after_frame: got valid %b len %0d expected valid 1 len 2", frame_valid, frame_len);
      end
      rd_addr = 4'd0;
      #1;
      checks++;
      if (rd_data !== 8'hA5) begin errors++; $display("FAIL rst_after_data0: got %h expected a5", rd_data); end
      rd_addr = 4'd1;
      #1;
      checks++;
      if (rd_data !== 8'h10) begin errors++; $display("FAIL rst_after_data1: got %h expected 10", rd_data); end
      // Reset while holding must drop the frame without waiting for a clock edge.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({frame_valid, frame_len} !== {1'b0, 5'd0}) begin
         errors++; $display("FAIL rst_hold: got valid %b len %0d expected valid 0 len 0", frame_valid, frame_len);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      rx_byte   = 8'h00;
      rx_valid  = 1'b0;
      frame_ack = 1'b0;
      rd_addr   = 4'd0;
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_length();
      test_timeout();
      test_overrun();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into length-prefixed, checksummed frames.
- Hunts for a sync byte, captures length and payload into an internal buffer, then verifies the checksum.
- Holds each good frame for the consumer until it is acknowledged.
- Sits directly behind the UART receiver, ahead of command decode; reports framing errors as single-cycle pulses.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame; power of two, 2..256.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 8680, clk cycles allowed between consecutive bytes inside a frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rx_byte  in  8  byte from UART receiver; sampled only when rx_valid=1.
- rx_valid  in  1  single-cycle strobe, byte available.
- frame_valid  out  1  good frame held in buffer; level signal.
- frame_len  out  $clog2(MAX_LEN)+1  payload length of held frame, 1..MAX_LEN.
- frame_ack  in  1  consumer releases the held frame.
- rd_addr  in  $clog2(MAX_LEN)  payload read index.
- rd_data  out  8  buf[rd_addr], combinational; defined only while frame_valid=1.
- err_len  out  1  pulse: LEN byte is 0 or greater than MAX_LEN.
- err_chk  out  1  pulse: checksum mismatch.
- err_timeout  out  1  pulse: inter-byte gap expired mid-frame.
- err_overrun  out  1  pulse: byte arrived while a frame was held.

Behaviour:
- Wire format: SYNC, LEN, LEN payload bytes, CHK.
- CHK = (LEN + sum of payload bytes) mod 256.
- Reset (async assert, clock-synchronous release):
  - state=HUNT; all outputs 0; checksum accumulator, byte index and timeout counter cleared.
  - Buffer contents are don't-care.
- States:
  - HUNT: on rx_valid with rx_byte==SYNC_BYTE, go to LEN. All other bytes are ignored silently.
  - LEN: on rx_valid, if byte is 0 or greater than MAX_LEN, pulse err_len and go to HUNT. Otherwise store len, acc=byte, idx=0, go to PAYLOAD.
  - PAYLOAD: on rx_valid, buf[idx]=byte, acc+=byte, idx++. When idx reaches len-1 on that write, go to CHECK.
  - CHECK: on rx_valid, if byte==acc, go to HOLD. Otherwise pulse err_chk and go to HUNT.
  - HOLD: frame_valid=1, frame_len=len. On frame_ack, go to HUNT.
- Timing and latency:
  - All transitions and error pulses are registered.
  - Each error pulse is exactly 1 cycle, in the cycle after the triggering rx_valid.
  - frame_valid rises the cycle after the CHK strobe.
  - frame_valid falls the cycle after frame_ack.
- Timeout:
  - Counter clears on every rx_valid and on entry to LEN.
  - Counter increments each cycle in LEN, PAYLOAD and CHECK.
  - When it reaches TIMEOUT_CLKS-1 with no rx_valid in that cycle: pulse err_timeout, go to HUNT.
  - rx_valid coincident with expiry: the byte wins, normal processing, no timeout.
  - Counter is inactive in HUNT and HOLD.
- HOLD overrun:
  - rx_valid without frame_ack: byte is dropped, err_overrun pulses.
  - Held frame and buffer are unchanged.
- frame_ack and rx_valid in the same HOLD cycle: the frame is released and the byte is processed as in HUNT. A SYNC byte here goes directly to LEN; no overrun is flagged.
- frame_ack outside HOLD is ignored.
- SYNC_BYTE appearing inside LEN, PAYLOAD or CHECK is treated as data; there is no resync.
- Arithmetic:
  - acc is 8-bit, wraps.
  - idx width is $clog2(MAX_LEN), so LEN==MAX_LEN fills every entry.
- Buffer writes occur only in PAYLOAD. rd_data stays stable for the whole of HOLD.

Decomposition:
- Package uart_frame_pkg:
  - state enum (HUNT, LEN, PAYLOAD, CHECK, HOLD);
  - default SYNC_BYTE constant;
  - checksum helper function.
- Sub-module uart_frame_buf: MAX_LEN x 8 register array with one synchronous write port and one combinational read port.
- The controller FSM, timeout counter and checksum accumulator stay in uart_rx_frame_ctrl.

Test Plan:
- Good frame A5,03,11,22,33,69 -> frame_valid=1, frame_len=3, rd_addr 0/1/2 gives 11/22/33; frame_ack -> frame_valid=0 next cycle.
- Bad checksum A5,02,01,02,00 -> err_chk one-cycle pulse, frame_valid stays 0; a following good frame is accepted.
- Length errors: LEN=00 -> err_len; LEN=MAX_LEN+1 -> err_len; LEN=MAX_LEN with correct CHK -> frame_len=MAX_LEN, all entries read back.
- Timeout: A5,04,AA then silence of TIMEOUT_CLKS cycles -> err_timeout. A byte strobed exactly on the expiry cycle -> no timeout.
- Overrun and same-cycle ack: while held, send 55 -> err_overrun and frame unchanged. Send A5 coincident with frame_ack -> no overrun, next frame is parsed from LEN.
- Reset mid-PAYLOAD (after A5,05,01) -> outputs 0 immediately. The subsequent good frame is received correctly; stray pre-reset bytes are ignored in HUNT.
